// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the memory-port arbiter.
`timescale 1ns/1ps
package mem_pkg;

    localparam int unsigned DEF_NUM_REQ     = 4;
    localparam int unsigned DEF_ADDR_W      = 8;
    localparam int unsigned DEF_DATA_W      = 8;
    localparam int unsigned DEF_TIMEOUT_CYC = 16;

    // IDLE: arbitrate; ISSUE: command held until ready; RELEASE: wait for ready to drop.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    // Increment modulo n, without a divider.
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and controller-side signals of the arbiter, bundled.
// master: the arbiter's view. slave: requesters plus the memory controller.
`timescale 1ns/1ps
interface mem_arbiter_if
    import mem_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W
) ();

    // Requester side (packed, requester i at [i*W +: W])
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_done;
    logic [NUM_REQ-1:0]        req_err;
    logic [DATA_W-1:0]         req_rdata;
    logic [NUM_REQ-1:0]        grant;

    // Controller side
    logic                      cmd_valid_sys;
    logic                      we_sys;
    logic [ADDR_W-1:0]         addr_sys;
    logic [DATA_W-1:0]         wdata_sys;
    logic                      ready_sys;
    logic [DATA_W-1:0]         rdata_sys;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, ready_sys, rdata_sys,
        output req_done, req_err, req_rdata, grant,
        output cmd_valid_sys, we_sys, addr_sys, wdata_sys
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, ready_sys, rdata_sys,
        input  req_done, req_err, req_rdata, grant,
        input  cmd_valid_sys, we_sys, addr_sys, wdata_sys
    );

endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first set bit of req at or after ptr,
// wrapping modulo NUM_REQ. gnt is one-hot (zero when req is zero).
`timescale 1ns/1ps
module rr_picker #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] index
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;
    logic             found;

    // Scan NUM_REQ candidates starting at ptr; ptr < NUM_REQ so one subtraction wraps.
    always_comb begin
        gnt      = '0;
        index    = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = cand[IDX_W-1:0];
            if (!found && req[cand_idx]) begin
                found         = 1'b1;
                gnt[cand_idx] = 1'b1;
                index         = cand_idx;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory-controller command port among
// NUM_REQ requesters. Each transaction is held until ready_sys, completed
// with a one-cycle done (or err on watchdog expiry), then the arbiter waits
// for ready_sys to fall so a stale ready cannot complete the next command.
`timescale 1ns/1ps
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned NUM_REQ     = DEF_NUM_REQ,
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.master bus
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    arb_state_t         state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   owner;
    logic [TMR_W-1:0]   timer;

    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] done_q;
    logic [NUM_REQ-1:0] err_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               cmd_valid_q;
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               any_req;
    logic [ADDR_W-1:0]  win_addr;
    logic [DATA_W-1:0]  win_wdata;
    logic               win_we;

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .gnt   (pick_gnt),
        .index (pick_idx)
    );

    // Command fields of the requester the picker currently favours.
    always_comb begin
        any_req   = |bus.req_valid;
        win_addr  = bus.req_addr[pick_idx*ADDR_W +: ADDR_W];
        win_wdata = bus.req_wdata[pick_idx*DATA_W +: DATA_W];
        win_we    = bus.req_we[pick_idx];
    end

    // Arbitration FSM, watchdog timer and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            owner       <= '0;
            timer       <= '0;
            grant_q     <= '0;
            done_q      <= '0;
            err_q       <= '0;
            rdata_q     <= '0;
            cmd_valid_q <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            // done/err are single-cycle pulses
            done_q <= '0;
            err_q  <= '0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_q     <= pick_gnt;
                        owner       <= pick_idx;
                        we_q        <= win_we;
                        addr_q      <= win_addr;
                        wdata_q     <= win_wdata;
                        cmd_valid_q <= 1'b1;
                        timer       <= '0;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer <= timer + 1'b1;
                    if (bus.ready_sys) begin
                        cmd_valid_q <= 1'b0;
                        done_q      <= grant_q;
                        if (!we_q) begin
                            rdata_q <= bus.rdata_sys;
                        end
                        timer <= '0;
                        state <= RELEASE;
                    end else if (timer == TMR_LAST) begin
                        // Controller never answered: abort the command.
                        cmd_valid_q <= 1'b0;
                        err_q       <= grant_q;
                        timer       <= '0;
                        state       <= RELEASE;
                    end
                end
                RELEASE: begin
                    timer <= timer + 1'b1;
                    // Leave once ready has dropped, or give up after the watchdog period.
                    if (!bus.ready_sys || timer == TMR_LAST) begin
                        grant_q <= '0;
                        rr_ptr  <= IDX_W'(wrap_inc(32'(owner), NUM_REQ));
                        timer   <= '0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant         = grant_q;
    assign bus.req_done      = done_q;
    assign bus.req_err       = err_q;
    assign bus.req_rdata     = rdata_q;
    assign bus.cmd_valid_sys = cmd_valid_q;
    assign bus.we_sys        = we_q;
    assign bus.addr_sys      = addr_q;
    assign bus.wdata_sys     = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a controller stub with configurable ready latency,
// a cycle-level reference of the arbitration rules, directed scenarios and
// a randomized traffic phase.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int TO = 16;

    logic clk;
    logic reset;

    mem_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(
        .NUM_REQ     (N),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- controller stub ----------------
    int         lat_cfg = 3;
    int         ctl_cnt;
    bit         mem_init = 0;
    logic [7:0] ctrl_mem [256];

    // ready rises lat_cfg edges after cmd_valid is first seen; falls once cmd_valid is seen low.
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int j = 0; j < 256; j++) ctrl_mem[j] <= 8'(j) ^ 8'h5A;
            mem_init <= 1;
        end
        if (reset) begin
            bus.ready_sys <= 1'b0;
            bus.rdata_sys <= '0;
            ctl_cnt       <= 0;
        end else if (bus.cmd_valid_sys) begin
            if (!bus.ready_sys) begin
                if (ctl_cnt + 1 >= lat_cfg) begin
                    bus.ready_sys <= 1'b1;
                    bus.rdata_sys <= ctrl_mem[bus.addr_sys];
                    if (bus.we_sys) ctrl_mem[bus.addr_sys] <= bus.wdata_sys;
                end
                ctl_cnt <= ctl_cnt + 1;
            end
        end else begin
            bus.ready_sys <= 1'b0;
            ctl_cnt       <= 0;
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    int         m_owner = -1;
    int         m_rr = 0;
    int         m_wait = 0;
    bit         m_acked = 0;
    bit         m_on = 0;
    bit         m_rst;
    logic [3:0] e_grant, e_done, e_err;
    logic       e_cv, e_we;
    logic [7:0] e_addr, e_wdata, e_rdata;
    logic [7:0] ref_mem [256];

    initial begin
        logic [3:0] rv;
        logic       rdy;
        for (int j = 0; j < 256; j++) ref_mem[j] = 8'(j) ^ 8'h5A;
        forever begin
            @(posedge clk);
            rv     = bus.req_valid;
            rdy    = bus.ready_sys;
            e_done = '0;
            e_err  = '0;
            m_rst  = 0;
            if (reset) begin
                m_on = 1; m_rst = 1;
                m_owner = -1; m_rr = 0; m_wait = 0; m_acked = 0;
                e_grant = '0; e_cv = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_rdata = '0;
            end else if (m_on && m_owner < 0) begin
                for (int k = 0; k < N; k++) begin
                    if (rv[(m_rr + k) % N]) begin
                        m_owner = (m_rr + k) % N;
                        break;
                    end
                end
                if (m_owner >= 0) begin
                    e_grant = '0;
                    e_grant[m_owner] = 1'b1;
                    e_cv    = 1;
                    e_we    = bus.req_we[m_owner];
                    e_addr  = bus.req_addr[m_owner*AW +: AW];
                    e_wdata = bus.req_wdata[m_owner*DW +: DW];
                    m_wait  = 0;
                    m_acked = 0;
                end
            end else if (m_on && !m_acked) begin
                m_wait++;
                if (rdy) begin
                    e_cv = 0; e_done[m_owner] = 1'b1; m_acked = 1; m_wait = 0;
                    if (e_we) ref_mem[e_addr] = e_wdata;
                    else e_rdata = ref_mem[e_addr];
                end else if (m_wait == TO) begin
                    e_cv = 0; e_err[m_owner] = 1'b1; m_acked = 1; m_wait = 0;
                end
            end else if (m_on) begin
                m_wait++;
                if (!rdy || m_wait == TO) begin
                    e_grant = '0;
                    m_rr    = (m_owner + 1) % N;
                    m_owner = -1;
                end
            end
            #1;
            if (m_on) begin
                chk("grant", bus.grant, e_grant);
                chk("cmd_valid", bus.cmd_valid_sys, e_cv);
                chk("req_done", bus.req_done, e_done);
                chk("req_err", bus.req_err, e_err);
                chk("grant_onehot0", $onehot0(bus.grant), 1);
                chk("done_err_excl", |(bus.req_done & bus.req_err), 0);
                if (e_cv || m_rst) begin
                    chk("we_sys", bus.we_sys, e_we);
                    chk("addr_sys", bus.addr_sys, e_addr);
                    chk("wdata_sys", bus.wdata_sys, e_wdata);
                end
                if ((e_done != 0 && !e_we) || m_rst) chk("req_rdata", bus.req_rdata, e_rdata);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    int         r_done_k, r_err_k, r_idle_k;
    bit         r_gstable;
    logic [7:0] r_rd, r_a1, r_d1;
    logic       r_cv1, r_we1;
    logic [3:0] order [8];
    int         rec_n;

    task automatic set_req(input int i, input bit we, input logic [7:0] a, input logic [7:0] d);
        bus.req_valid[i]         = 1'b1;
        bus.req_we[i]            = we;
        bus.req_addr[i*AW +: AW] = a;
        bus.req_wdata[i*DW +: DW] = d;
    endtask

    function automatic int oh_idx(input logic [3:0] g);
        for (int i = 0; i < N; i++) if (g[i]) return i;
        return -1;
    endfunction

    // One request from requester i; k=1 is the edge that samples it.
    task automatic run_one(input int i, input bit we, input logic [7:0] a, input logic [7:0] d);
        logic [3:0] gi;
        gi = 4'(1 << i);
        @(negedge clk);
        set_req(i, we, a, d);
        r_done_k = -1; r_err_k = -1; r_idle_k = -1; r_gstable = 1;
        for (int k = 1; k <= 3*TO; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                r_cv1 = bus.cmd_valid_sys; r_a1 = bus.addr_sys;
                r_d1 = bus.wdata_sys; r_we1 = bus.we_sys;
            end
            if (bus.req_done[i]) begin r_done_k = k; r_rd = bus.req_rdata; end
            if (bus.req_err[i]) r_err_k = k;
            if (bus.grant == 0) begin r_idle_k = k; break; end
            if (bus.grant != gi) r_gstable = 0;
            if (bus.req_done[i] || bus.req_err[i]) begin
                @(negedge clk);
                bus.req_valid[i] = 1'b0;
            end
        end
        @(negedge clk);
        bus.req_valid[i] = 1'b0;
    endtask

    // Assert a set of write requests; a requester re-requests after done until n grants seen.
    task automatic record_grants(input logic [3:0] mask, input int n);
        int         ngr;
        logic [3:0] prev_g, drop;
        bit         drained;
        ngr = 0; drained = 0;
        @(negedge clk);
        for (int i = 0; i < N; i++) if (mask[i]) set_req(i, 1'b1, 8'(8'h40 + i), 8'($urandom));
        prev_g = bus.grant;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk); #1;
            if (bus.grant != 0 && prev_g == 0) begin
                if (ngr < 8) order[ngr] = bus.grant;
                ngr++;
            end
            prev_g = bus.grant;
            drop = '0;
            for (int i = 0; i < N; i++) if (bus.req_done[i] && ngr >= n) drop[i] = 1'b1;
            @(negedge clk);
            bus.req_valid = bus.req_valid & ~drop;
            if (bus.req_valid == 0 && bus.grant == 0) begin drained = 1; break; end
        end
        chk("record_drained", drained, 1);
        bus.req_valid = '0;
        rec_n = ngr;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit drained;
        reset = 1'b1;
        bus.req_valid = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_grant", bus.grant, 4'b0000);
        chk("rst_cmd_valid", bus.cmd_valid_sys, 0);
        chk("rst_rdata", bus.req_rdata, 8'h00);
        reset = 1'b0;

        // Single write: done 4 cycles after the request edge, idle 2 later.
        run_one(0, 1'b1, 8'h12, 8'hA5);
        chk("wr_cmd_valid", r_cv1, 1);
        chk("wr_addr", r_a1, 8'h12);
        chk("wr_wdata", r_d1, 8'hA5);
        chk("wr_we", r_we1, 1);
        chk("wr_done_latency", r_done_k - 1, 4);
        chk("wr_idle_k", r_idle_k, 7);
        chk("wr_mem", ctrl_mem[8'h12], 8'hA5);

        // Single read by requester 2.
        run_one(2, 1'b0, 8'h12, 8'h00);
        chk("rd_done_seen", r_done_k > 0, 1);
        chk("rd_data", r_rd, 8'hA5);
        chk("rd_grant_stable", r_gstable, 1);

        // Contention from rr_ptr=0.
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        record_grants(4'b1111, 5);
        chk("cont_count", rec_n >= 5, 1);
        chk("cont_g0", order[0], 4'b0001);
        chk("cont_g1", order[1], 4'b0010);
        chk("cont_g2", order[2], 4'b0100);
        chk("cont_g3", order[3], 4'b1000);
        chk("cont_g4", order[4], 4'b0001);

        // Wrap/fairness: last grant 3, then 3 and 1 together -> 1 first.
        run_one(3, 1'b1, 8'h50, 8'h33);
        record_grants(4'b1010, 2);
        chk("wrap_first", order[0], 4'b0010);
        chk("wrap_second", order[1], 4'b1000);

        // Watchdog abort.
        lat_cfg = 1000;
        run_one(1, 1'b0, 8'h12, 8'h00);
        chk("to_no_done", r_done_k, 32'hFFFF_FFFF);
        chk("to_err_cycle", r_err_k - 1, TO);
        chk("to_idle_bound", (r_idle_k > 0) && (r_idle_k - 1 <= 2*TO), 1);
        lat_cfg = 3;

        // Reset during ISSUE of a read.
        lat_cfg = 10;
        @(negedge clk);
        set_req(1, 1'b0, 8'h12, 8'h00);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        bus.req_valid = '0;
        @(posedge clk); #1;
        chk("mid_rst_grant", bus.grant, 4'b0000);
        chk("mid_rst_cv", bus.cmd_valid_sys, 0);
        chk("mid_rst_done", bus.req_done, 4'b0000);
        chk("mid_rst_err", bus.req_err, 4'b0000);
        @(negedge clk);
        reset = 1'b0;
        lat_cfg = 3;
        run_one(1, 1'b0, 8'h12, 8'h00);
        chk("post_rst_rd", r_rd, 8'hA5);
        chk("post_rst_latency", r_done_k - 1, 4);

        // Randomized traffic.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (!bus.cmd_valid_sys)
                lat_cfg = ($urandom_range(0, 9) < 8) ? int'($urandom_range(1, 4)) : 40;
            for (int i = 0; i < N; i++) begin
                if (bus.req_valid[i]) begin
                    if (bus.req_done[i] || bus.req_err[i]) begin
                        if ($urandom_range(0, 3) == 0)
                            set_req(i, 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom));
                        else
                            bus.req_valid[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    set_req(i, 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom));
                end
            end
        end
        drained = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++)
                if (bus.req_done[i] || bus.req_err[i]) bus.req_valid[i] = 1'b0;
            if (bus.req_valid == 0 && bus.grant == 0) begin drained = 1; break; end
        end
        chk("random_drained", drained, 1);

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
